scan_sequencer: RTL

- Sequential channel-index generator that sits directly upstream of the 3-to-8 decoder.
- Its 3-bit sel output drives the decoder's d input, so the decoder's one-hot q walks across 8 channels.
- Supports programmable dwell per channel, up/down direction, synchronous load, and per-channel skip masking.
- Used for LED/display scanning and round-robin channel enables.

---
 rtl/scan_if.sv | 28 ++
 rtl/scan_sequencer.sv | 93 +++++++++
 2 files changed

// File: rtl/scan_if.sv
// scan_sequencer control/status bundle.
// Master drives scan controls, slave returns channel status.
interface scan_if #(
  parameter int DWELL_W = 4
);
  logic               en;
  logic               dir;
  logic               load;
  logic [2:0]         load_val;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         skip_mask;
  logic [2:0]         sel;
  logic               step;
  logic               wrap;
  logic               busy;

  modport master (
    output en, dir, load, load_val,
    output dwell, skip_mask,
    input  sel, step, wrap, busy
  );

  modport slave (
    input  en, dir, load, load_val,
    input  dwell, skip_mask,
    output sel, step, wrap, busy
  );
endinterface

// File: rtl/scan_sequencer.sv
// Channel-index scanner feeding a 3-to-8 decoder.
// Dwell, direction, skip mask and load control.
module scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input logic  clk,
  input logic  rst,
  scan_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [2:0]         sel_q;
  logic               step_q;
  logic               wrap_q;
  logic               busy_q;

  logic [2:0] sel_d;
  logic       found_d;
  logic       wrap_d;

  // Pick the nearest unmasked channel in the scan direction.
  always_comb begin
    logic [2:0] ofs;
    logic [2:0] cand;
    sel_d   = sel_q;
    found_d = 1'b0;
    ofs     = '0;
    cand    = '0;
    for (int k = 1; k < 8; k++) begin
      ofs  = k[2:0];
      cand = bus.dir ? sel_q - ofs : sel_q + ofs;
      if (!found_d && !bus.skip_mask[cand]) begin
        found_d = 1'b1;
        sel_d   = cand;
      end
    end
    wrap_d = bus.dir ? (sel_d > sel_q)
                     : (sel_d < sel_q);
  end

  // FSM, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (bus.load) begin
      sel_q  <= bus.load_val;
      cnt_q  <= '0;
      step_q <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.en) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q >= bus.dwell) begin
            cnt_q <= '0;
            if (found_d) begin
              sel_q  <= sel_d;
              step_q <= 1'b1;
              wrap_q <= wrap_d;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel  = sel_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = busy_q;
endmodule
